// File: rtl/pg_fault_sequencer.sv
// pg_fault_sequencer: validates fault inject/clear requests, drains the mesh, applies and settles the broadcast pg_en/pg_node config.
module pg_fault_sequencer #(
  parameter int MESH_X     = 8,
  parameter int MESH_Y     = 8,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_TMO  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [5:0] req_node,
  output logic       drain_req,
  input  logic       drain_ack,
  output logic       pg_en,
  output logic [5:0] pg_node,
  output logic       cfg_active,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] DRAIN  = 3'd2;
  localparam logic [2:0] APPLY  = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] ACTIVE = 3'd5;
  localparam logic [7:0] TMO_LAST    = 8'(DRAIN_TMO - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  logic [2:0] state;
  logic       op;
  logic [5:0] node;
  logic [7:0] cnt;
  logic       bad_coord;
  logic [2:0] home;

  // The stable state always tracks pg_en, so aborts return to whichever matches the unchanged config.
  assign home       = pg_en ? ACTIVE : IDLE;
  assign req_ready  = state == IDLE || state == ACTIVE;
  assign busy       = !req_ready;
  assign drain_req  = state == DRAIN || state == APPLY || state == SETTLE;
  assign cfg_active = state == ACTIVE;
  assign bad_coord  = 32'(node[2:0]) >= 32'(MESH_X) || 32'(node[5:3]) >= 32'(MESH_Y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= 1'b0;
      node      <= '0;
      cnt       <= '0;
      pg_en     <= 1'b0;
      pg_node   <= '0;
      err_pulse <= 1'b0;
      err_code  <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, ACTIVE: if (req_valid) begin
          op       <= req_op;
          node     <= req_node;
          err_code <= '0;
          state    <= CHECK;
        end
        CHECK: if (!op && (bad_coord || pg_en)) begin
          err_code  <= bad_coord ? 2'b01 : 2'b11;
          err_pulse <= 1'b1;
          state     <= home;
        end else if (op && !pg_en) begin
          state <= IDLE;
        end else begin
          cnt   <= '0;
          state <= DRAIN;
        end
        DRAIN: if (drain_ack) begin
          cnt   <= '0;
          state <= APPLY;
        end else if (cnt == TMO_LAST) begin
          err_code  <= 2'b10;
          err_pulse <= 1'b1;
          state     <= home;
        end else begin
          cnt <= cnt + 8'd1;
        end
        APPLY: begin
          pg_en   <= !op;
          pg_node <= op ? 6'd0 : node;
          state   <= SETTLE;
        end
        SETTLE: if (cnt == SETTLE_LAST) state <= pg_en ? ACTIVE : IDLE;
        else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pg_fault_sequencer.sv
// tb_pg_fault_sequencer: directed and randomized requests checked cycle by cycle against a transaction-level timeline model.
module tb_pg_fault_sequencer;
  localparam int MX = 4, MY = 6, SC = 4, TMO = 10;

  logic       clk = 0, rst_n = 0, req_valid = 0, req_op = 0, drain_ack = 0;
  logic [5:0] req_node = 0;
  logic       req_ready, drain_req, pg_en, cfg_active, busy, err_pulse;
  logic [5:0] pg_node;
  logic [1:0] err_code;

  pg_fault_sequencer #(.MESH_X(MX), .MESH_Y(MY), .SETTLE_CYC(SC), .DRAIN_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_node(req_node), .drain_req(drain_req), .drain_ack(drain_ack), .pg_en(pg_en),
    .pg_node(pg_node), .cfg_active(cfg_active), .busy(busy), .err_pulse(err_pulse), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic       m_en = 0;
  logic [5:0] m_node = 0;
  logic [1:0] m_code = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {req_ready,busy,drain_req,cfg_active,err_pulse,err_code,pg_en,pg_node}
  function automatic logic [31:0] obs();
    return {18'b0, req_ready, busy, drain_req, cfg_active, err_pulse, err_code, pg_en, pg_node};
  endfunction

  function automatic logic [31:0] vec(input logic rdy, input logic bsy, input logic dr, input logic act,
                                      input logic ep, input logic [1:0] code, input logic en, input logic [5:0] nd);
    return {18'b0, rdy, bsy, dr, act, ep, code, en, nd};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = 0;
      drain_ack = 1'($urandom);
      @(negedge clk);
      chk("idle", obs(), vec(1, 0, 0, m_en, 0, m_code, m_en, m_node));
    end
  endtask

  // d: cycles of DRAIN before drain_ack rises (d>=TMO means never); rst_k: cycle to pulse rst_n (0 = none)
  task automatic req(input logic op, input logic [5:0] node, input int d, input int rst_k);
    int kind, dl, t;
    logic bad, dr, upd;
    logic [1:0] code;
    logic n_en;
    logic [5:0] n_node;
    bad = int'(node[2:0]) >= MX || int'(node[5:3]) >= MY;
    code = 0; n_en = m_en; n_node = m_node; dl = 0;
    if (!op && bad) begin kind = 0; code = 2'b01; end
    else if (!op && m_en) begin kind = 0; code = 2'b11; end
    else if (op && !m_en) kind = 1;
    else if (d >= TMO) begin kind = 2; code = 2'b10; dl = TMO; end
    else begin kind = 3; dl = d + 1; n_en = !op; n_node = op ? 6'd0 : node; end
    t = kind < 2 ? 2 : kind == 2 ? 2 + dl : 3 + dl + SC;
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_node = node;
    @(negedge clk);
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    for (int k = 1; k <= t; k++) begin
      req_valid = k < t ? 1'($urandom) : 1'b0;
      req_op = 1'($urandom);
      req_node = 6'($urandom);
      drain_ack = (k >= 2 && k < 2 + d) ? 1'b0 : (k == 2 + d) ? 1'b1 : 1'($urandom);
      if (k == rst_k) begin
        req_valid = 0;
        #1 rst_n = 0;
        #1 chk("async_reset", obs(), vec(1, 0, 0, 0, 0, 2'b00, 0, 6'd0));
        #1 rst_n = 1;
        m_en = 0; m_node = 0; m_code = 0;
        @(negedge clk);
        chk("post_reset", obs(), vec(1, 0, 0, 0, 0, 2'b00, 0, 6'd0));
        return;
      end
      dr = kind >= 2 && k >= 2 && k <= (kind == 3 ? 2 + dl + SC : 1 + dl);
      upd = kind == 3 && k >= 3 + dl;
      @(negedge clk);
      chk($sformatf("op%0d_node%0h_d%0d_cyc%0d", op, node, d, k), obs(),
          vec(k >= t, k < t, dr, k >= t && n_en, k == t && code != 0, k >= t ? code : 2'b00,
              upd ? n_en : m_en, upd ? n_node : m_node));
      if (k < t) begin @(posedge clk); #1; end
    end
    m_en = n_en; m_node = n_node; m_code = code;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", obs(), vec(1, 0, 0, 0, 0, 2'b00, 0, 6'd0));
    rst_n = 1;
    idle(2);
    req(0, 6'b101_011, 2, 0);
    req(0, 6'b001_010, 0, 0);
    req(1, 6'd0, 1, 0);
    req(0, 6'b000_101, 0, 0);
    req(1, 6'b111_111, 0, 0);
    req(0, 6'b010_001, TMO, 0);
    req(0, 6'b010_001, 1, 6);
    req(0, 6'b010_001, 0, 0);
    idle(1);
    repeat (60) begin
      logic op;
      int d;
      op = 1'($urandom);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      req(op, 6'($urandom), d, 0);
      idle($urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
